// File: rtl/final_flush_ctrl.sv
// rtl/final_flush_ctrl.sv - end-of-frame entropy encoder flush sequencer
//
// Latches the final cnt/low on a flush request, enables final_bits_generator
// for one evaluation cycle, captures its flag and words, then emits 0, 1 or 2
// words over a valid/ready handshake and pulses completion.
//
// Ports:
//   clk, reset                       clock (rising edge), async active-low reset
//   in_final_req, in_cnt, in_low     flush request and final encoder state
//   out_gen_flag_final               generator isolation enable (EVAL only)
//   out_gen_cnt, out_gen_low         latched cnt/low driven to the generator
//   in_gen_flag, in_gen_bit_1/2      generator word count and words
//   out_valid, in_ready, out_data    output word handshake
//   out_last                         current word is the final flush word
//   out_busy, out_done, out_words    flush status
//   out_err                          request dropped while busy (pulse)
module final_flush_ctrl #(
  parameter int OUTPUT_BITSTREAM_WIDTH = 16,
  parameter int D_SIZE                 = 5,
  parameter int LOW_WIDTH              = 24
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              in_final_req,
  input  logic [D_SIZE-1:0]                 in_cnt,
  input  logic [LOW_WIDTH-1:0]              in_low,
  output logic                              out_gen_flag_final,
  output logic [D_SIZE-1:0]                 out_gen_cnt,
  output logic [LOW_WIDTH-1:0]              out_gen_low,
  input  logic [1:0]                        in_gen_flag,
  input  logic [OUTPUT_BITSTREAM_WIDTH-1:0] in_gen_bit_1,
  input  logic [OUTPUT_BITSTREAM_WIDTH-1:0] in_gen_bit_2,
  output logic                              out_valid,
  input  logic                              in_ready,
  output logic [OUTPUT_BITSTREAM_WIDTH-1:0] out_data,
  output logic                              out_last,
  output logic                              out_busy,
  output logic                              out_done,
  output logic [1:0]                        out_words,
  output logic                              out_err
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_EVAL  = 3'd1,
    S_EMIT1 = 3'd2,
    S_EMIT2 = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t state_q, state_d;

  logic [1:0]                        flag_q;
  logic [OUTPUT_BITSTREAM_WIDTH-1:0] bit_1_q;
  logic [OUTPUT_BITSTREAM_WIDTH-1:0] bit_2_q;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; the EVAL decision uses the generator flag live, which is
  // the same value captured into flag_q on that edge.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (in_final_req) state_d = S_EVAL;
      S_EVAL:  state_d = (in_gen_flag == 2'b00) ? S_DONE : S_EMIT1;
      S_EMIT1: if (in_ready) state_d = flag_q[1] ? S_EMIT2 : S_DONE;
      S_EMIT2: if (in_ready) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_gen_cnt <= '0;
      out_gen_low <= '0;
      flag_q      <= 2'b00;
      bit_1_q     <= '0;
      bit_2_q     <= '0;
      out_words   <= 2'd0;
      out_err     <= 1'b0;
    end else begin
      if (state_q == S_IDLE && in_final_req) begin
        out_gen_cnt <= in_cnt;
        out_gen_low <= in_low;
      end
      if (state_q == S_EVAL) begin
        flag_q  <= in_gen_flag;
        bit_1_q <= in_gen_bit_1;
        bit_2_q <= in_gen_bit_2;
        // Code 11 is treated as a two-word flush, same as 10.
        case (in_gen_flag)
          2'b00:   out_words <= 2'd0;
          2'b01:   out_words <= 2'd1;
          default: out_words <= 2'd2;
        endcase
      end
      out_err <= in_final_req && (state_q != S_IDLE);
    end
  end

  // Outputs decoded from registered state; data/last come from captured
  // registers so they stay stable under backpressure.
  always_comb begin
    out_gen_flag_final = 1'b0;
    out_valid          = 1'b0;
    out_data           = '0;
    out_last           = 1'b0;
    out_busy           = (state_q != S_IDLE);
    out_done           = 1'b0;
    case (state_q)
      S_EVAL:  out_gen_flag_final = 1'b1;
      S_EMIT1: begin
        out_valid = 1'b1;
        out_data  = bit_1_q;
        out_last  = (flag_q == 2'b01);
      end
      S_EMIT2: begin
        out_valid = 1'b1;
        out_data  = bit_2_q;
        out_last  = 1'b1;
      end
      S_DONE:  out_done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: doc/final_flush_ctrl.md
Name: final_flush_ctrl

Overview:
- Sequences the end-of-frame flush of the entropy encoder, i.e. the OD_EC_ENC_DONE tail.
- On a final request it latches the encoder's final cnt/low and drives final_bits_generator for exactly one evaluation cycle, with the isolation enable high only in that cycle.
- It captures the generator's flag and words, then emits 0, 1 or 2 bitstream words over a valid/ready handshake to the output packer.
- It signals completion, and sits between stage_4 and the bitstream output buffer.

Parameters:
- OUTPUT_BITSTREAM_WIDTH, 16, width of each emitted word
- D_SIZE, 5, width of cnt
- LOW_WIDTH, 24, width of low

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- in_final_req  in  1  one-cycle flush request (stage_4 final flag)
- in_cnt  in  D_SIZE  final cnt, sampled with in_final_req
- in_low  in  LOW_WIDTH  final low, sampled with in_final_req
- out_gen_flag_final  out  1  generator isolation enable
- out_gen_cnt  out  D_SIZE  latched cnt to generator
- out_gen_low  out  LOW_WIDTH  latched low to generator
- in_gen_flag  in  2  generator word-count flag
- in_gen_bit_1  in  OUTPUT_BITSTREAM_WIDTH  generator word 1
- in_gen_bit_2  in  OUTPUT_BITSTREAM_WIDTH  generator word 2
- out_valid  out  1  output word valid
- in_ready  in  1  downstream accepts word
- out_data  out  OUTPUT_BITSTREAM_WIDTH  output word
- out_last  out  1  current word is final flush word
- out_busy  out  1  flush in progress
- out_done  out  1  one-cycle flush-complete pulse
- out_words  out  2  number of words emitted by the last flush
- out_err  out  1  one-cycle pulse: request dropped while busy

Behaviour:
- Reset (asynchronous, reset=0):
  - State is IDLE.
  - All outputs are 0: out_gen_cnt, out_gen_low, out_data, out_words, out_valid, out_last, out_busy, out_done, out_err, out_gen_flag_final.
  - Reset mid-flush abandons the flush: no further words and no out_done.
- States are IDLE, EVAL, EMIT1, EMIT2, DONE. All outputs are registered or decoded from registered state.
- IDLE:
  - in_final_req=1 latches in_cnt/in_low into out_gen_cnt/out_gen_low, sets out_busy=1 and moves to EVAL.
  - The latched cnt/low values hold until the next accepted request.
- EVAL (exactly 1 cycle):
  - out_gen_flag_final=1; it is 0 in every other state.
  - At the clock edge, capture in_gen_flag, in_gen_bit_1 and in_gen_bit_2 into internal registers.
  - Transition on the captured flag:
    - flag 00: go to DONE, out_words=0.
    - flag 01: go to EMIT1 with word 1 marked last, out_words=1.
    - flag 10 or 11: go to EMIT1, out_words=2. Code 11 is treated as 10.
- EMIT1:
  - out_valid=1, out_data=captured bit_1, out_last=1 only for flag 01.
  - On in_ready=1: go to EMIT2 for a two-word flush, otherwise go to DONE.
- EMIT2:
  - out_valid=1, out_data=captured bit_2, out_last=1.
  - On in_ready=1: go to DONE.
- Backpressure: while out_valid=1 and in_ready=0, out_data and out_last hold stable. There is no timeout.
- DONE (1 cycle): out_done=1, out_busy=0 from the next cycle, return to IDLE.
  - A new in_final_req is accepted in the cycle after DONE (in IDLE), not in DONE itself.
- Request while not IDLE: the request is ignored, out_err pulses 1 cycle in the following cycle, and the flush in progress is unaffected.
- in_ready while out_valid=0 is ignored.
- out_words is updated in EVAL and holds until the next EVAL.
- Latency, no backpressure, from the request edge:
  - EVAL is cycle +1.
  - Word 1 is valid at cycle +2.
  - Word 2 is valid at cycle +3.
  - out_done is at the cycle after the last handshake, or cycle +2 for a zero-word flush.
- cnt is treated as 5-bit two's-complement modular. The controller never inspects cnt; the word count comes only from in_gen_flag.
- out_gen_cnt and out_gen_low hold their values outside EVAL. Isolation is done by out_gen_flag_final=0 at the generator.

Test Plan (generator instantiated behind the controller):
- cnt=0, low=0x000000, in_ready=1 → flag 01. One word out_data=0x0080 with out_last=1 at request+2. out_done at +3, out_words=1.
- cnt=8, low=0x000000, in_ready=1 → flag 10. Word 1 out_data=0x0000 with last=0 at +2. Word 2 out_data=0x0080 with last=1 at +3. out_done at +4, out_words=2.
- cnt=5'h1F (−1), low=0 → flag 00. No out_valid at any time, out_done at +2, out_words=0.
- cnt=8, low=0, in_ready held 0 for 5 cycles after word 1 appears → out_data=0x0000 stable throughout. Word 2 appears the cycle after ready rises, and total words=2.
- Second in_final_req during EMIT1 → out_err pulse next cycle, first flush completes unchanged, no second flush. Request after out_done is accepted normally.
- reset asserted during EMIT2 with in_ready=0 → all outputs 0 immediately, no out_done. After release, a new request runs a full flush.
